coax_rx: RTL and testbench
==========================

Name: coax_rx

Overview:
- Receive-side counterpart of the coax transmitter; same line encoding, same bit period.
- Recovers bit timing from the incoming Manchester-style line and hunts for line quiesce followed by a code violation.
- Then decodes sync-bit-framed 10-bit words, MSB first.
- Delivers each word as a one-cycle strobe to the interface controller and flags framing/timing errors.

Parameters:
- CLOCKS_PER_BIT, 8: clk cycles per bit cell; even, >=8.
- QUIESCE_MIN, 4: consecutive quiesce '1' bits required before a code violation is accepted.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- rx  input  1  raw line input, asynchronous to clk.
- active  output  1  high from code-violation acceptance until frame end or error.
- data  output  10  last received word; bit 9 = first bit on line.
- data_valid  output  1  one-cycle strobe; data valid in the same cycle.
- error  output  1  one-cycle strobe on framing/timing/parity error.

Behaviour:
- Reset (async, reset_n low): state=HUNT, active=0, data=0, data_valid=0, error=0, sync flops=0, timer=0, counters=0.
- Input sync: rx passes through 2 flops; edge detect on the 2nd vs a 3rd flop. Detected edge = rise/fall event, 3 clk latency from rx.
- Bit encoding: '1' = low then high, rising edge at mid-cell; '0' = high then low, falling edge at mid-cell. Boundary edges are ignored.
- timer: counts clk since the last accepted mid-cell edge, or since the last edge in run-length states.
  - Saturates at 2*CLOCKS_PER_BIT.
  - Clears on every event it is measuring.
- Windows, in clk with C=CLOCKS_PER_BIT:
  - mid-cell edge: timer in [3C/4, 5C/4].
  - boundary edge: timer < 3C/4.
  - long run: [5C/4, 7C/4].
- HUNT:
  - Count rising edges spaced within the mid-cell window; any other spacing resets the count to 1.
  - When count >= QUIESCE_MIN and a falling edge arrives at timer in [C/4, 3C/4] -> CV_LOW; timer cleared.
- CV_LOW:
  - Rising edge with timer in long-run window -> CV_HIGH, timer cleared.
  - Any other edge, or timer > 7C/4 -> HUNT, no error.
- CV_HIGH:
  - Falling edge in long-run window -> SYNC, active=1, timer cleared.
  - Otherwise -> HUNT, no error.
- SYNC:
  - Rising edge with timer in [C/4, 3C/4] (first sync) or the mid-cell window (subsequent words) -> DATA, bit_count=0, timer cleared.
  - Falling edge in the mid-cell window (sync=0) -> error pulse, HUNT.
  - Timer > 5C/4 with no edge:
    - after at least one word -> frame end: HUNT, active=0, no error.
    - before any word -> error, HUNT.
- DATA:
  - Edge in mid-cell window: shift {shreg, rising}, bit_count+1, timer cleared.
  - Boundary edges ignored.
  - Timer > 5C/4 -> error pulse, HUNT, active=0.
  - After the 10th bit:
    - data<=shreg, data_valid=1 the next cycle (one cycle only).
    - -> SYNC (expect next word's sync bit); prior timer reference kept.
- data holds its value until the next valid word; it is not cleared on error.
- error and data_valid never assert in the same cycle.
- Edge with timer exactly at a window limit counts as inside.
- Saturated timer never wraps.

Optional Feature:
- COAX_RX_PARITY_EN defined:
  - After the 10 data bits, DATA takes an 11th bit: even parity over the 10 bits plus the parity bit.
  - Match: data_valid as above, one cycle after the parity bit.
  - Mismatch: error pulse instead of data_valid; data not updated; state -> SYNC (frame continues).
- Undefined: 10-bit words, no parity; logic absent.

Test Plan:
- Drive the transmitter's frame (6 quiesce, CV, sync, word 10'b0000000101, then line low) with C=8 -> exactly one data_valid, data=10'h005; active rises on CV_HIGH exit, falls 5C/4+3 clk after the last mid-cell edge; error never asserts.
- Two words back-to-back (10'h3FF, then sync and 10'h200) -> two data_valid pulses, 11 bit-times apart, data 10'h3FF then 10'h200; active stays high between them.
- Code violation low run of 8 clk instead of 12 -> stays in HUNT: active, data_valid and error all remain 0; a following correct frame decodes normally.
- Remove the mid-cell edge of data bit 4 -> one error pulse 5C/4 clk after bit 3; active=0; no data_valid; data keeps its previous value.
- reset_n low mid-word for 1 clk -> all outputs 0 immediately; the rest of the word produces no data_valid; the next full frame decodes.
- With COAX_RX_PARITY_EN: word 10'h005 with parity bit 0 -> data_valid, data=10'h005; parity bit 1 -> error pulse, no data_valid.

Source files
------------

// File: rtl/coax_rx_if.sv
// Line and word-delivery signals of the coax receiver.
// The line side drives rx; the receiver returns the decoded word, its strobe,
// the frame-active flag and the error strobe.
interface coax_rx_if;
    logic       rx;
    logic       active;
    logic [9:0] data;
    logic       data_valid;
    logic       error;

    modport master (
        output rx,
        input  active,
        input  data,
        input  data_valid,
        input  error
    );

    modport slave (
        input  rx,
        output active,
        output data,
        output data_valid,
        output error
    );
endinterface

// File: rtl/coax_rx.sv
// coax_rx: receive side of the coax link.
// Synchronises the raw line, measures edge spacing with a saturating timer,
// hunts for quiesce '1' bits followed by a long-low/long-high code violation,
// then decodes sync-bit-framed 10-bit words (MSB first) into a one-cycle strobe.
// Optional build macro COAX_RX_PARITY_EN adds an 11th even-parity bit per word.
module coax_rx #(
    parameter int CLOCKS_PER_BIT = 8,
    parameter int QUIESCE_MIN    = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    coax_rx_if.slave bus
);
    localparam int C  = CLOCKS_PER_BIT;
    localparam int TW = $clog2(2 * C + 1);
    localparam int QW = $clog2(QUIESCE_MIN + 1);

    localparam logic [TW-1:0] T_Q1  = TW'(C / 4);
    localparam logic [TW-1:0] T_Q3  = TW'((3 * C) / 4);
    localparam logic [TW-1:0] T_Q5  = TW'((5 * C) / 4);
    localparam logic [TW-1:0] T_Q7  = TW'((7 * C) / 4);
    localparam logic [TW-1:0] T_SAT = TW'(2 * C);
    localparam logic [QW-1:0] Q_MIN = QW'(QUIESCE_MIN);

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_CV_LOW  = 3'd1,
        ST_CV_HIGH = 3'd2,
        ST_SYNC    = 3'd3,
        ST_DATA    = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_sync1, r_sync2, r_sync3;
    logic [TW-1:0]   r_timer;
    logic [QW-1:0]   r_qcnt;
    logic [3:0]      r_bitcnt;
    logic [9:0]      r_shreg;
    logic            r_got_word;
    logic            r_active;
    logic [9:0]      r_data;
    logic            r_data_valid;
    logic            r_error;

    logic            w_rise, w_fall, w_edge;
    logic            w_tmid, w_thalf, w_tlong, w_tover5, w_tover7, w_sync_win;
    logic [9:0]      w_shift;
    logic            w_timer_clr;
    logic [QW-1:0]   w_qcnt_nxt;
    logic [3:0]      w_bitcnt_nxt;
    logic [9:0]      w_shreg_nxt;
    logic            w_got_word_nxt;
    logic            w_active_nxt;
    logic [9:0]      w_data_nxt;
    logic            w_dv_nxt;
    logic            w_err_nxt;

`ifdef COAX_RX_PARITY_EN
    // True when the ten data bits plus the parity bit hold an even count of ones.
    function automatic logic parity_ok(input logic [9:0] word, input logic pbit);
        return ~(^{word, pbit});
    endfunction
`endif

    assign w_rise     = r_sync2 & ~r_sync3;
    assign w_fall     = ~r_sync2 & r_sync3;
    assign w_edge     = w_rise | w_fall;
    assign w_tmid     = (r_timer >= T_Q3) && (r_timer <= T_Q5);
    assign w_thalf    = (r_timer >= T_Q1) && (r_timer <= T_Q3);
    assign w_tlong    = (r_timer >= T_Q5) && (r_timer <= T_Q7);
    assign w_tover5   = (r_timer > T_Q5);
    assign w_tover7   = (r_timer > T_Q7);
    // The first sync bit follows the code violation by half a cell; later ones a full cell.
    assign w_sync_win = r_got_word ? w_tmid : w_thalf;
    assign w_shift    = {r_shreg[8:0], w_rise};

    // Two-flop synchroniser for the asynchronous line plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= bus.rx;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode from the current state, edge type and timer windows.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HUNT: begin
                if (w_fall && (r_qcnt >= Q_MIN) && w_thalf) w_state_nxt = ST_CV_LOW;
                else                                        w_state_nxt = ST_HUNT;
            end
            ST_CV_LOW: begin
                if (w_rise && w_tlong)          w_state_nxt = ST_CV_HIGH;
                else if (w_edge || w_tover7)    w_state_nxt = ST_HUNT;
                else                            w_state_nxt = ST_CV_LOW;
            end
            ST_CV_HIGH: begin
                if (w_fall && w_tlong)          w_state_nxt = ST_SYNC;
                else if (w_edge || w_tover7)    w_state_nxt = ST_HUNT;
                else                            w_state_nxt = ST_CV_HIGH;
            end
            ST_SYNC: begin
                if (w_rise && w_sync_win)       w_state_nxt = ST_DATA;
                else if (w_fall && w_tmid)      w_state_nxt = ST_HUNT;
                else if (w_tover5)              w_state_nxt = ST_HUNT;
                else                            w_state_nxt = ST_SYNC;
            end
            ST_DATA: begin
                if (w_edge && w_tmid) begin
`ifdef COAX_RX_PARITY_EN
                    if (r_bitcnt == 4'd10)      w_state_nxt = ST_SYNC;
                    else                        w_state_nxt = ST_DATA;
`else
                    if (r_bitcnt == 4'd9)       w_state_nxt = ST_SYNC;
                    else                        w_state_nxt = ST_DATA;
`endif
                end else if (w_tover5) begin
                    w_state_nxt = ST_HUNT;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            default: w_state_nxt = ST_HUNT;
        endcase
    end

    // Datapath and output decode: timer clears, quiesce count, shifter and strobes.
    always_comb begin
        w_timer_clr    = 1'b0;
        w_qcnt_nxt     = r_qcnt;
        w_bitcnt_nxt   = r_bitcnt;
        w_shreg_nxt    = r_shreg;
        w_got_word_nxt = r_got_word;
        w_active_nxt   = r_active;
        w_data_nxt     = r_data;
        w_dv_nxt       = 1'b0;
        w_err_nxt      = 1'b0;
        case (r_state)
            ST_HUNT: begin
                w_active_nxt = 1'b0;
                if (w_rise) begin
                    // Quiesce '1' bits give rising edges one cell apart.
                    w_timer_clr = 1'b1;
                    if (w_tmid) w_qcnt_nxt = (r_qcnt >= Q_MIN) ? r_qcnt : r_qcnt + QW'(1);
                    else        w_qcnt_nxt = QW'(1);
                end else if (w_fall && (r_qcnt >= Q_MIN) && w_thalf) begin
                    w_timer_clr = 1'b1;
                end else begin
                    w_timer_clr = 1'b0;
                end
            end
            ST_CV_LOW: begin
                if (w_rise && w_tlong) begin
                    w_timer_clr = 1'b1;
                end else if (w_rise) begin
                    // A rise half a cell after the boundary is just another quiesce bit.
                    w_timer_clr = 1'b1;
                    w_qcnt_nxt  = w_thalf ? r_qcnt : QW'(1);
                end else if (w_fall || w_tover7) begin
                    w_qcnt_nxt = '0;
                end else begin
                    w_qcnt_nxt = r_qcnt;
                end
            end
            ST_CV_HIGH: begin
                if (w_fall && w_tlong) begin
                    w_timer_clr    = 1'b1;
                    w_active_nxt   = 1'b1;
                    w_got_word_nxt = 1'b0;
                end else if (w_rise) begin
                    w_timer_clr = 1'b1;
                    w_qcnt_nxt  = QW'(1);
                end else if (w_fall || w_tover7) begin
                    w_qcnt_nxt = '0;
                end else begin
                    w_qcnt_nxt = r_qcnt;
                end
            end
            ST_SYNC: begin
                if (w_rise && w_sync_win) begin
                    w_timer_clr  = 1'b1;
                    w_bitcnt_nxt = 4'd0;
                end else if (w_fall && w_tmid) begin
                    w_err_nxt    = 1'b1;
                    w_active_nxt = 1'b0;
                    w_qcnt_nxt   = '0;
                end else if (w_tover5) begin
                    // Silence after a word is a clean frame end; before any word it is an error.
                    w_err_nxt    = ~r_got_word;
                    w_active_nxt = 1'b0;
                    w_qcnt_nxt   = '0;
                end else begin
                    w_timer_clr = 1'b0;
                end
            end
            ST_DATA: begin
                if (w_edge && w_tmid) begin
                    w_timer_clr = 1'b1;
`ifdef COAX_RX_PARITY_EN
                    if (r_bitcnt == 4'd10) begin
                        w_got_word_nxt = 1'b1;
                        w_bitcnt_nxt   = 4'd0;
                        if (parity_ok(r_shreg, w_rise)) begin
                            w_data_nxt = r_shreg;
                            w_dv_nxt   = 1'b1;
                        end else begin
                            w_err_nxt  = 1'b1;
                        end
                    end else begin
                        w_shreg_nxt  = w_shift;
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                    end
`else
                    w_shreg_nxt  = w_shift;
                    w_bitcnt_nxt = r_bitcnt + 4'd1;
                    if (r_bitcnt == 4'd9) begin
                        w_data_nxt     = w_shift;
                        w_dv_nxt       = 1'b1;
                        w_got_word_nxt = 1'b1;
                    end else begin
                        w_dv_nxt = 1'b0;
                    end
`endif
                end else if (w_tover5) begin
                    w_err_nxt    = 1'b1;
                    w_active_nxt = 1'b0;
                    w_qcnt_nxt   = '0;
                end else begin
                    w_timer_clr = 1'b0;
                end
            end
            default: begin
                w_active_nxt = 1'b0;
                w_qcnt_nxt   = '0;
            end
        endcase
    end

    // Registered datapath, saturating edge timer and outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer      <= '0;
            r_qcnt       <= '0;
            r_bitcnt     <= 4'd0;
            r_shreg      <= 10'd0;
            r_got_word   <= 1'b0;
            r_active     <= 1'b0;
            r_data       <= 10'd0;
            r_data_valid <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            if (w_timer_clr)          r_timer <= TW'(1);
            else if (r_timer < T_SAT) r_timer <= r_timer + TW'(1);
            else                      r_timer <= r_timer;
            r_qcnt       <= w_qcnt_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_shreg      <= w_shreg_nxt;
            r_got_word   <= w_got_word_nxt;
            r_active     <= w_active_nxt;
            r_data       <= w_data_nxt;
            r_data_valid <= w_dv_nxt;
            r_error      <= w_err_nxt;
        end
    end

    assign bus.active     = r_active;
    assign bus.data       = r_data;
    assign bus.data_valid = r_data_valid;
    assign bus.error      = r_error;
endmodule

// File: tb/tb_coax_rx.sv
// Directed bench for coax_rx: drives transmitter-style frames bit by bit and
// checks decoded words, strobes, active flag and error timing.
module tb_coax_rx;
    localparam int C = 8;
`ifdef COAX_RX_PARITY_EN
    localparam int WORD_BITS = 11;
`else
    localparam int WORD_BITS = 10;
`endif

    logic clk;
    logic reset_n;
    coax_rx_if bus_if ();

    coax_rx #(.CLOCKS_PER_BIT(C), .QUIESCE_MIN(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int dv_cnt = 0, err_cnt = 0, both_cnt = 0, rise_cnt = 0, fall_cnt = 0;
    logic [9:0] dv_q[$];
    longint dv_tq[$];
    longint err_t = 0, rise_t = 0, fall_t = 0;
    logic prev_act = 1'b0;

    longint last_mid_t = 0, cv_end_t = 0;
    longint bit_t[10];
`ifdef COAX_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    // Output monitor, sampled on the falling edge away from the DUT's active edge.
    always @(negedge clk) begin
        if (bus_if.data_valid) begin
            dv_cnt++;
            dv_q.push_back(bus_if.data);
            dv_tq.push_back($time);
        end
        if (bus_if.error) begin
            err_cnt++;
            err_t = $time;
        end
        if (bus_if.error && bus_if.data_valid) both_cnt++;
        if (bus_if.active && !prev_act) begin rise_cnt++; rise_t = $time; end
        if (!bus_if.active && prev_act) begin fall_cnt++; fall_t = $time; end
        prev_act = bus_if.active;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input longint obs, input longint lo, input longint hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        bus_if.rx = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus_if.rx = ~b;
        repeat (C / 2) @(negedge clk);
        bus_if.rx = b;
        last_mid_t = $time;
        repeat (C / 2) @(negedge clk);
    endtask

    task automatic send_word(input logic [9:0] w, input int skip);
        for (int i = 0; i < 10; i++) begin
            if (i == skip) begin
                hold(bus_if.rx, C);
            end else begin
                send_bit(w[9 - i]);
                bit_t[i] = last_mid_t;
            end
        end
`ifdef COAX_RX_PARITY_EN
        send_bit((^w) ^ par_flip);
`endif
    endtask

    task automatic send_preamble(input int cv_low);
        repeat (6) send_bit(1'b1);
        hold(1'b0, cv_low);
        hold(1'b1, (3 * C) / 2);
        cv_end_t = $time;
    endtask

    task automatic send_frame(input logic [9:0] w0, input logic [9:0] w1, input int nwords,
                              input int cv_low, input int skip);
        send_preamble(cv_low);
        send_bit(1'b1);
        send_word(w0, skip);
        if (nwords > 1) begin
            send_bit(1'b1);
            send_word(w1, -1);
        end
        hold(1'b0, 3 * C);
    endtask

    int dv0, err0, rise0, fall0;
    logic [9:0] wr;

    initial begin
        reset_n   = 1'b0;
        bus_if.rx = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_active", bus_if.active, 32'd0);
        check("reset_data", bus_if.data, 32'd0);
        check("reset_dv", bus_if.data_valid, 32'd0);
        check("reset_err", bus_if.error, 32'd0);
        reset_n = 1'b1;
        hold(1'b0, 2 * C);

        // Single word 10'h005 frame.
        dv0 = dv_cnt; err0 = err_cnt; rise0 = rise_cnt; fall0 = fall_cnt;
        send_frame(10'h005, 10'h000, 1, (3 * C) / 2, -1);
        check("a_dv_count", dv_cnt - dv0, 32'd1);
        check("a_data", bus_if.data, 32'h005);
        check("a_no_error", err_cnt - err0, 32'd0);
        check("a_active_rise", rise_cnt - rise0, 32'd1);
        check("a_active_fall", fall_cnt - fall0, 32'd1);
        check_rng("a_rise_delay", (rise_t - cv_end_t) / 10, 2, 4);
        check_rng("a_fall_delay", (fall_t - last_mid_t) / 10, 12, 15);
        check("a_active_end", bus_if.active, 32'd0);

        // Two back-to-back words.
        dv0 = dv_cnt; err0 = err_cnt; rise0 = rise_cnt; fall0 = fall_cnt;
        send_frame(10'h3FF, 10'h200, 2, (3 * C) / 2, -1);
        check("b_dv_count", dv_cnt - dv0, 32'd2);
        check("b_word0", dv_q[dv_q.size() - 2], 32'h3FF);
        check("b_word1", dv_q[dv_q.size() - 1], 32'h200);
        check("b_spacing", dv_tq[dv_tq.size() - 1] - dv_tq[dv_tq.size() - 2],
              32'((WORD_BITS + 1) * C * 10));
        check("b_active_one_rise", rise_cnt - rise0, 32'd1);
        check("b_active_one_fall", fall_cnt - fall0, 32'd1);
        check("b_no_error", err_cnt - err0, 32'd0);

        // Short code-violation low run: must stay hunting.
        dv0 = dv_cnt; err0 = err_cnt; rise0 = rise_cnt;
        send_frame(10'h005, 10'h000, 1, C, -1);
        check("c_no_active", rise_cnt - rise0, 32'd0);
        check("c_no_dv", dv_cnt - dv0, 32'd0);
        check("c_no_error", err_cnt - err0, 32'd0);
        send_frame(10'h2C3, 10'h000, 1, (3 * C) / 2, -1);
        check("c_recover_dv", dv_cnt - dv0, 32'd1);
        check("c_recover_data", bus_if.data, 32'h2C3);

        // Missing mid-cell edge on bit 4.
        dv0 = dv_cnt; err0 = err_cnt;
        send_frame(10'h155, 10'h000, 1, (3 * C) / 2, 4);
        check("d_error_count", err_cnt - err0, 32'd1);
        check_rng("d_error_delay", (err_t - bit_t[3]) / 10, 12, 15);
        check("d_no_dv", dv_cnt - dv0, 32'd0);
        check("d_data_kept", bus_if.data, 32'h2C3);
        check("d_active_low", bus_if.active, 32'd0);

        // Reset pulse in the middle of a word.
        wr = 10'h3C5;
        send_preamble((3 * C) / 2);
        send_bit(1'b1);
        for (int i = 0; i < 5; i++) send_bit(wr[9 - i]);
        bus_if.rx = ~wr[4];
        @(negedge clk);
        check("e_active_before", bus_if.active, 32'd1);
        reset_n = 1'b0;
        #1;
        check("e_active_rst", bus_if.active, 32'd0);
        check("e_data_rst", bus_if.data, 32'd0);
        check("e_dv_rst", bus_if.data_valid, 32'd0);
        check("e_err_rst", bus_if.error, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        dv0 = dv_cnt;
        repeat (C / 2 - 2) @(negedge clk);
        bus_if.rx = wr[4];
        repeat (C / 2) @(negedge clk);
        for (int i = 6; i < 10; i++) send_bit(wr[9 - i]);
        hold(1'b0, 3 * C);
        check("e_no_dv_after", dv_cnt - dv0, 32'd0);
        send_frame(10'h1E7, 10'h000, 1, (3 * C) / 2, -1);
        check("e_next_dv", dv_cnt - dv0, 32'd1);
        check("e_next_data", bus_if.data, 32'h1E7);

`ifdef COAX_RX_PARITY_EN
        // Parity: correct bit delivers, flipped bit raises error.
        dv0 = dv_cnt; err0 = err_cnt;
        par_flip = 1'b0;
        send_frame(10'h005, 10'h000, 1, (3 * C) / 2, -1);
        check("f_par_ok_dv", dv_cnt - dv0, 32'd1);
        check("f_par_ok_data", bus_if.data, 32'h005);
        check("f_par_ok_err", err_cnt - err0, 32'd0);
        dv0 = dv_cnt; err0 = err_cnt;
        par_flip = 1'b1;
        send_frame(10'h005, 10'h000, 1, (3 * C) / 2, -1);
        check("f_par_bad_err", err_cnt - err0, 32'd1);
        check("f_par_bad_dv", dv_cnt - dv0, 32'd0);
        par_flip = 1'b0;
`endif

        check("never_both", both_cnt, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
